// File: rtl/des_pkg.sv
// des_pkg -- shared DES constants and helpers.
// Contents: FSM state type, the IP/FP/E/P/PC-1/PC-2 permutation tables
// (FIPS 46-3 numbering, entry = 1-based source bit), the S1..S8 boxes,
// the key-rotation schedule, and the helpers permute(), sbox() and the
// 28-bit rotations used by the key schedule.
// Bit convention everywhere: DES bit 1 is the MSB of the vector.
package des_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Tables shorter than 64 entries are zero-padded; permute() never reads
  // past out_w entries.
  typedef int perm_t [64];

  localparam perm_t IP_T = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam perm_t FP_T = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

  localparam perm_t E_T = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  localparam perm_t P_T = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  localparam perm_t PC1_T = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4,
    0, 0, 0, 0, 0, 0, 0, 0};

  localparam perm_t PC2_T = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Each S-box row packs its 16 nibbles with column 0 in the top nibble.
  localparam logic [63:0] SBOX [8][4] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}};

  // Output is right-aligned in out_w bits; input is an in_w-bit value
  // right-aligned in din.
  function automatic logic [63:0] permute(input logic [63:0] din, input int in_w,
                                          input perm_t tbl, input int out_w);
    logic [63:0] dout;
    logic [5:0]  src;
    logic [5:0]  dst;
    dout = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < out_w) begin
        src = 6'(in_w - tbl[6'(i)]);
        dst = 6'(out_w - 1 - i);
        dout[dst] = din[src];
      end
    end
    return dout;
  endfunction

  // Row = outer bits, column = middle four; ~col selects nibble 15-col.
  function automatic logic [3:0] sbox(input int s, input logic [5:0] six);
    return 4'(SBOX[3'(s)][{six[5], six[0]}] >> {~six[4:1], 2'b00});
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] v, input int n);
    return (n == 2) ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] v, input int n);
    return (n == 2) ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

endpackage

// File: rtl/des_round.sv
// des_round -- one combinational DES Feistel round.
// Ports: l_in/r_in (32) current halves, subkey (48) round key,
//        l_out/r_out (32) halves after the round (l_out = r_in,
//        r_out = l_in ^ f(r_in, subkey)).
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l_in,
  input  logic [31:0] r_in,
  input  logic [47:0] subkey,
  output logic [31:0] l_out,
  output logic [31:0] r_out
);

  logic [47:0] mixed;
  logic [31:0] sbox_out;
  logic [31:0] f_out;

  assign mixed = 48'(permute(64'(r_in), 32, E_T, 48)) ^ subkey;

  for (genvar gi = 0; gi < 8; gi++) begin : g_sbox
    assign sbox_out[31-4*gi -: 4] = sbox(gi, mixed[47-6*gi -: 6]);
  end

  assign f_out = 32'(permute(64'(sbox_out), 32, P_T, 32));
  assign l_out = r_in;
  assign r_out = l_in ^ f_out;

endmodule

// File: rtl/encrypt.sv
// encrypt -- iterative DES engine, one round per clock, 16 cycles per block.
// Parameter DES_TYPE: 0 = encrypt, 1 = decrypt (subkeys K16..K1).
// Ports: clk, rst (sync, active-high), data (64) input block, data_vld
//        start strobe (ignored while running), key (64, parity bits
//        ignored), result (64) held until the next completion, result_vld
//        one-cycle completion pulse.
// Optional: define DES_BUSY_EN to add output busy, high while in RUN.
module encrypt
  import des_pkg::*;
#(
  parameter logic DES_TYPE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data,
  input  logic        data_vld,
  input  logic [63:0] key,
  output logic [63:0] result,
`ifdef DES_BUSY_EN
  output logic        busy,
`endif
  output logic        result_vld
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [63:0] result_q, result_d;
  logic        result_vld_q, result_vld_d;

  logic [63:0] ip_data;
  logic [55:0] pc1_key;
  logic [27:0] c_key, d_key, c_adv, d_adv;
  logic [47:0] subkey;
  logic [31:0] l_nxt, r_nxt;

  assign ip_data = permute(data, 64, IP_T, 64);
  assign pc1_key = 56'(permute(key, 64, PC1_T, 56));

  // Encrypt rotates left before using C/D for a round. Decrypt starts from
  // C16/D16 (equal to C0/D0, the rotations total 28) and rotates right
  // after each round, undoing the shift of the round it just used.
  always_comb begin
    if (DES_TYPE) begin
      c_key = c_q;
      d_key = d_q;
      c_adv = rotr28(c_q, SHIFTS[~cnt_q]);
      d_adv = rotr28(d_q, SHIFTS[~cnt_q]);
    end else begin
      c_key = rotl28(c_q, SHIFTS[cnt_q]);
      d_key = rotl28(d_q, SHIFTS[cnt_q]);
      c_adv = c_key;
      d_adv = d_key;
    end
  end

  assign subkey = 48'(permute({8'h00, c_key, d_key}, 56, PC2_T, 48));

  des_round u_round (
    .l_in   (l_q),
    .r_in   (r_q),
    .subkey (subkey),
    .l_out  (l_nxt),
    .r_out  (r_nxt)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    l_d          = l_q;
    r_d          = r_q;
    c_d          = c_q;
    d_d          = d_q;
    result_d     = result_q;
    result_vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_vld) begin
          l_d     = ip_data[63:32];
          r_d     = ip_data[31:0];
          c_d     = pc1_key[55:28];
          d_d     = pc1_key[27:0];
          cnt_d   = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        l_d   = l_nxt;
        r_d   = r_nxt;
        c_d   = c_adv;
        d_d   = d_adv;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          // Last round: halves are swapped before the final permutation.
          result_d     = permute({r_nxt, l_nxt}, 64, FP_T, 64);
          result_vld_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      l_q          <= '0;
      r_q          <= '0;
      c_q          <= '0;
      d_q          <= '0;
      result_q     <= '0;
      result_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      l_q          <= l_d;
      r_q          <= r_d;
      c_q          <= c_d;
      d_q          <= d_d;
      result_q     <= result_d;
      result_vld_q <= result_vld_d;
    end
  end

  assign result     = result_q;
  assign result_vld = result_vld_q;
`ifdef DES_BUSY_EN
  assign busy       = (state_q == RUN);
`endif

endmodule

// File: tb/tb_encrypt.sv
// tb_encrypt -- self-checking bench for encrypt. One encrypt and one decrypt
// instance share all stimulus; results are compared with a standalone DES
// model written from the FIPS 46-3 tables. Honours DES_BUSY_EN.
module tb_encrypt;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data;
  logic        data_vld;
  logic [63:0] key;
  logic [63:0] res_enc, res_dec;
  logic        vld_enc, vld_dec;
`ifdef DES_BUSY_EN
  logic        busy_enc, busy_dec;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  encrypt #(.DES_TYPE(1'b0)) dut_enc (
    .clk(clk), .rst(rst), .data(data), .data_vld(data_vld), .key(key),
    .result(res_enc),
`ifdef DES_BUSY_EN
    .busy(busy_enc),
`endif
    .result_vld(vld_enc));

  encrypt #(.DES_TYPE(1'b1)) dut_dec (
    .clk(clk), .rst(rst), .data(data), .data_vld(data_vld), .key(key),
    .result(res_dec),
`ifdef DES_BUSY_EN
    .busy(busy_dec),
`endif
    .result_vld(vld_dec));

  // ---------------- reference model ----------------
  localparam int TB_IP [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  localparam int TB_FP [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  localparam int TB_E [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int TB_P [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int TB_PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int TB_PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int TB_SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int TB_SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // DES bit n (1 = MSB) of a w-bit value held right-aligned in v.
  function automatic logic pick(input logic [63:0] v, input int w, input int n);
    logic [5:0] idx;
    idx = 6'(w - n);
    return v[idx];
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] blk, input logic [63:0] k, input bit dec);
    logic [63:0] acc;
    logic [55:0] cd;
    logic [47:0] ks [16];
    logic [31:0] l, r, s, t;
    logic [47:0] x;
    logic [5:0]  six;
    acc = '0;
    for (int i = 0; i < 56; i++) acc = {acc[62:0], pick(k, 64, TB_PC1[6'(i)])};
    cd = 56'(acc);
    for (int n = 0; n < 16; n++) begin
      for (int j = 0; j < TB_SHIFT[4'(n)]; j++) cd = {cd[54:28], cd[55], cd[26:0], cd[27]};
      acc = '0;
      for (int i = 0; i < 48; i++) acc = {acc[62:0], pick(64'(cd), 56, TB_PC2[6'(i)])};
      ks[4'(n)] = 48'(acc);
    end
    acc = '0;
    for (int i = 0; i < 64; i++) acc = {acc[62:0], pick(blk, 64, TB_IP[6'(i)])};
    l = acc[63:32];
    r = acc[31:0];
    for (int n = 0; n < 16; n++) begin
      acc = '0;
      for (int i = 0; i < 48; i++) acc = {acc[62:0], pick(64'(r), 32, TB_E[6'(i)])};
      x = 48'(acc) ^ ks[4'(dec ? 15 - n : n)];
      s = '0;
      for (int b = 0; b < 8; b++) begin
        six = 6'(x >> (42 - 6 * b));
        s = {s[27:0], 4'(TB_SBOX[3'(b)][{six[5], six[0], six[4:1]}])};
      end
      acc = '0;
      for (int i = 0; i < 32; i++) acc = {acc[62:0], pick(64'(s), 32, TB_P[5'(i)])};
      t = r;
      r = l ^ 32'(acc);
      l = t;
    end
    acc = '0;
    for (int i = 0; i < 64; i++) acc = {acc[62:0], pick({r, l}, 64, TB_FP[6'(i)])};
    return acc;
  endfunction

  // ---------------- checking and stimulus ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Call at a negedge; returns at the negedge after the accept edge with
  // data/key scrambled so a late sample would show up.
  task automatic launch(input logic [63:0] d, input logic [63:0] k);
    data = d;
    key = k;
    data_vld = 1'b1;
    step();
    data_vld = 1'b0;
    data = {$urandom, $urandom};
    key = {$urandom, $urandom};
  endtask

  // Waits (bounded) for completion; optionally pulses a junk data_vld at
  // cycle 'inject' of the run.
  task automatic await_result(input string tag, input logic [63:0] exp_enc,
                              input logic [63:0] exp_dec, input int inject);
    int cyc;
    cyc = 0;
    while (!vld_enc && cyc < 40) begin
`ifdef DES_BUSY_EN
      check({tag, ".busy"}, 64'(busy_enc), 64'd1);
`endif
      if (cyc == inject) begin
        data_vld = 1'b1;
        data = {$urandom, $urandom};
        key = {$urandom, $urandom};
      end else begin
        data_vld = 1'b0;
      end
      step();
      cyc++;
    end
    data_vld = 1'b0;
    check({tag, ".lat"}, 64'(cyc), 64'd16);
    check({tag, ".enc"}, res_enc, exp_enc);
    check({tag, ".dec"}, res_dec, exp_dec);
    check({tag, ".dvld"}, 64'(vld_dec), 64'd1);
`ifdef DES_BUSY_EN
    check({tag, ".idle"}, 64'(busy_enc), 64'd0);
`endif
    $display("xact %s: enc=%h dec=%h latency=%0d", tag, res_enc, res_dec, cyc);
  endtask

  localparam logic [63:0] K0 = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT = 64'h636F6D7075746572;
  localparam logic [63:0] CT = 64'h5808300BCDD61868;

  initial begin
    logic [63:0] da, ka, db, kb;
    int hits;
    rst = 1'b1;
    data_vld = 1'b0;
    data = '0;
    key = '0;
    repeat (3) step();
    check("rst.enc", res_enc, 64'h0);
    check("rst.dec", res_dec, 64'h0);
    check("rst.evld", 64'(vld_enc), 64'd0);
    check("rst.dvld", 64'(vld_dec), 64'd0);
`ifdef DES_BUSY_EN
    check("rst.busy", 64'(busy_enc), 64'd0);
`endif
    rst = 1'b0;
    step();

    // Known-answer vectors.
    launch(PT, K0);
    await_result("kat_enc", CT, des_ref(PT, K0, 1'b1), -1);
    step();
    check("kat_enc.pulse", 64'(vld_enc), 64'd0);
    check("kat_enc.hold", res_enc, CT);
    launch(CT, K0);
    await_result("kat_dec", des_ref(CT, K0, 1'b0), PT, -1);
    launch(64'h0123456789ABCDEF, K0);
    await_result("kat3", 64'h85E813540F0AB405, des_ref(64'h0123456789ABCDEF, K0, 1'b1), -1);
    launch(64'h0123456789ABCDEF, K0 ^ 64'h0101010101010101);
    await_result("kat3_par", 64'h85E813540F0AB405, des_ref(64'h0123456789ABCDEF, K0, 1'b1), -1);

    // Strobe during RUN is ignored; strobe in the result_vld cycle is taken.
    da = {$urandom, $urandom};
    ka = {$urandom, $urandom};
    db = {$urandom, $urandom};
    kb = {$urandom, $urandom};
    launch(da, ka);
    await_result("ignore", des_ref(da, ka, 1'b0), des_ref(da, ka, 1'b1), 5);
    launch(db, kb);
    check("b2b.pulse", 64'(vld_enc), 64'd0);
    check("b2b.hold", res_enc, des_ref(da, ka, 1'b0));
    await_result("b2b", des_ref(db, kb, 1'b0), des_ref(db, kb, 1'b1), -1);

    // Reset in the middle of a run aborts it.
    step();
    launch(da, kb);
    repeat (8) step();
    rst = 1'b1;
    step();
`ifdef DES_BUSY_EN
    check("abort.busy", 64'(busy_enc), 64'd0);
`endif
    rst = 1'b0;
    hits = 0;
    repeat (30) begin
      if (vld_enc || vld_dec) hits++;
      step();
    end
    check("abort.vld", 64'(hits), 64'd0);
    check("abort.enc", res_enc, 64'h0);
    check("abort.dec", res_dec, 64'h0);

    // Reset wins over a simultaneous start.
    rst = 1'b1;
    data_vld = 1'b1;
    data = db;
    key = ka;
    step();
    rst = 1'b0;
    data_vld = 1'b0;
    hits = 0;
    repeat (20) begin
      if (vld_enc || vld_dec) hits++;
      step();
    end
    check("rstvld.vld", 64'(hits), 64'd0);
    launch(db, ka);
    await_result("post_rst", des_ref(db, ka, 1'b0), des_ref(db, ka, 1'b1), -1);

    // Random blocks with random idle gaps.
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) step();
      da = {$urandom, $urandom};
      ka = {$urandom, $urandom};
      launch(da, ka);
      await_result($sformatf("rand%0d", n), des_ref(da, ka, 1'b0), des_ref(da, ka, 1'b1), -1);
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
